incrementer: RTL and testbench
==============================

Name: incrementer

Overview:
- Fetch-stage program-counter incrementer.
- Combinational path: computes next sequential address pcout = pcin + STEP (default 4) for the fetch mux.
- Also holds an optional registered PC (pc_q) with enable and redirect load, for fetch units that keep their PC locally.
- Sits between the PC register/redirect mux and instruction-memory address logic.

Parameters:
- WIDTH, 32, address width in bits.
- STEP, 4, increment added per sequential fetch (bytes per instruction).
- RESET_PC, 32'h0000_0000, value loaded into pc_q on reset.

Ports:
- clk  input  1  clock; rising-edge active; used only by the registered PC.
- rst  input  1  asynchronous active-high reset; affects only the registered PC.
- pcin  input  WIDTH  current PC for the combinational increment.
- pcout  output  WIDTH  pcin + STEP, modulo 2^WIDTH.
- wrap  output  1  carry-out of pcin + STEP (1 when the sum overflowed).
- misaligned  output  1  1 when pcin[1:0] != 0 (pcin not word-aligned).
- en  input  1  advance pc_q by STEP on the next clock edge.
- load  input  1  redirect: load pc_q from load_addr on the next clock edge.
- load_addr  input  WIDTH  redirect target (branch/jump).
- pc_q  output  WIDTH  registered PC.
- pc_next_q  output  WIDTH  pc_q + STEP, combinational from pc_q.

Behaviour:
- Interface: one clock (clk); reset rst is asynchronous and active-high.

Combinational path:
- pcout = pcin + STEP, zero latency, no dependence on clk or rst.
- Must be valid even if clk never toggles and rst is undriven.
- Arithmetic is unsigned, truncated to WIDTH; the carry appears on wrap.
- Example: 0xFFFF_FFFC + 4 gives pcout = 0x0000_0000 and wrap = 1.
- No alignment correction: an unaligned pcin is incremented as-is (3 gives 7) and misaligned = 1.
- pcout, wrap and misaligned update within the same delta as any pcin change.

Registered PC:
- rst = 1: pc_q = RESET_PC immediately, asynchronously, and is held while rst is high.
- Rising clk edge with rst = 0, in priority order:
  - load = 1: pc_q <= load_addr, regardless of en.
  - else en = 1: pc_q <= pc_q + STEP (mod 2^WIDTH, silent wrap).
  - else: pc_q holds.
- pc_next_q = pc_q + STEP, combinational.
- Reset values: pc_q = RESET_PC; pc_next_q = RESET_PC + STEP.
- Reset asserted mid-operation overrides any pending load or en.
- First edge after rst deasserts applies load/en normally.
- load_addr is not required to be aligned and is loaded verbatim.
- No X-propagation suppression; pure synthesizable logic; no latches.

Test Plan:
- Comb sweep at 5-time-unit steps: pcin 0, 30, 3, 200, 9996 -> pcout 4, 34, 7, 204, 10000; wrap = 0; misaligned = 0, 1, 1, 0, 0.
- pcin = 0xFFFF_FFFC -> pcout = 0x0000_0000, wrap = 1; pcin = 0xFFFF_FFFF -> pcout = 3, wrap = 1, misaligned = 1.
- Assert rst with no clock -> pc_q = 0, pc_next_q = 4 immediately; with clk idle, a pcin change still updates pcout.
- Release rst, en = 1 for 3 edges -> pc_q = 4, 8, 12; then en = 0 for 2 edges -> pc_q holds at 12.
- load = 1, en = 1, load_addr = 0x100 -> pc_q = 0x100 after one edge (load wins); next edge with en only -> 0x104.
- Assert rst between edges while en = 1 -> pc_q drops to 0 immediately, stays 0 until release, then increments to 4.

Source files
------------

// File: rtl/incrementer.sv
// incrementer: fetch-stage PC incrementer with a combinational pcin + STEP path
// and an optional registered PC with enable and redirect load.
module incrementer #(
    parameter int               WIDTH    = 32,
    parameter int               STEP     = 4,
    parameter logic [WIDTH-1:0] RESET_PC = '0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] pcin,
    output logic [WIDTH-1:0] pcout,
    output logic             wrap,
    output logic             misaligned,
    input  logic             en,
    input  logic             load,
    input  logic [WIDTH-1:0] load_addr,
    output logic [WIDTH-1:0] pc_q,
    output logic [WIDTH-1:0] pc_next_q
);
    // Widen by one bit so the carry-out lands on wrap.
    assign {wrap, pcout} = {1'b0, pcin} + (WIDTH+1)'(STEP);
    assign misaligned    = |pcin[1:0];
    assign pc_next_q     = pc_q + WIDTH'(STEP);

    always_ff @(posedge clk or posedge rst)
        if (rst)       pc_q <= RESET_PC;
        else if (load) pc_q <= load_addr;
        else if (en)   pc_q <= pc_next_q;
endmodule

// File: tb/tb_incrementer.sv
// tb_incrementer: directed self-checking bench for incrementer.
module tb_incrementer;
    logic        clk = 1'b0, clk_run = 1'b0;
    logic        rst = 1'b0, en = 1'b0, load = 1'b0;
    logic [31:0] pcin = '0, load_addr = '0;
    logic [31:0] pcout, pc_q, pc_next_q;
    logic        wrap, misaligned;
    int          tests = 0, fails = 0;

    incrementer dut (
        .clk(clk), .rst(rst), .pcin(pcin), .pcout(pcout), .wrap(wrap),
        .misaligned(misaligned), .en(en), .load(load), .load_addr(load_addr),
        .pc_q(pc_q), .pc_next_q(pc_next_q)
    );

    always begin
        #5;
        if (clk_run) clk = ~clk;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_comb();
        logic [31:0] vin  [5] = '{32'd0, 32'd30, 32'd3, 32'd200, 32'd9996};
        logic [31:0] vout [5] = '{32'd4, 32'd34, 32'd7, 32'd204, 32'd10000};
        logic        vmis [5] = '{1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
        for (int i = 0; i < 5; i++) begin
            pcin = vin[i];
            #5;
            tests++;
            if (pcout !== vout[i]) begin fails++; $display("FAIL comb_pcout[%0d]: got %0d expected %0d", i, pcout, vout[i]); end
            tests++;
            if (wrap !== 1'b0) begin fails++; $display("FAIL comb_wrap[%0d]: got %b expected 0", i, wrap); end
            tests++;
            if (misaligned !== vmis[i]) begin fails++; $display("FAIL comb_misaligned[%0d]: got %b expected %b", i, misaligned, vmis[i]); end
        end
    endtask

    task automatic test_wrap();
        pcin = 32'hFFFF_FFFC;
        #5;
        tests++;
        if (pcout !== 32'h0 || wrap !== 1'b1 || misaligned !== 1'b0) begin
            fails++; $display("FAIL wrap_fffffffc: got pcout=%h wrap=%b mis=%b expected 00000000 1 0", pcout, wrap, misaligned);
        end
        pcin = 32'hFFFF_FFFF;
        #5;
        tests++;
        if (pcout !== 32'h3 || wrap !== 1'b1 || misaligned !== 1'b1) begin
            fails++; $display("FAIL wrap_ffffffff: got pcout=%h wrap=%b mis=%b expected 00000003 1 1", pcout, wrap, misaligned);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        #1;
        tests++;
        if (pc_q !== 32'h0) begin fails++; $display("FAIL reset_pc_q: got %h expected 00000000", pc_q); end
        tests++;
        if (pc_next_q !== 32'h4) begin fails++; $display("FAIL reset_pc_next_q: got %h expected 00000004", pc_next_q); end
        pcin = 32'd100;
        #1;
        tests++;
        if (pcout !== 32'd104) begin fails++; $display("FAIL reset_idle_pcout: got %0d expected 104", pcout); end
        rst = 1'b0;
        #1;
    endtask

    task automatic test_count();
        logic [31:0] exp [3] = '{32'd4, 32'd8, 32'd12};
        en = 1'b1;
        clk_run = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            tests++;
            if (pc_q !== exp[i]) begin fails++; $display("FAIL count_en[%0d]: got %0d expected %0d", i, pc_q, exp[i]); end
        end
        en = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            tests++;
            if (pc_q !== 32'd12) begin fails++; $display("FAIL count_hold[%0d]: got %0d expected 12", i, pc_q); end
        end
    endtask

    task automatic test_load();
        load = 1'b1; en = 1'b1; load_addr = 32'h100;
        tick();
        tests++;
        if (pc_q !== 32'h100) begin fails++; $display("FAIL load_wins: got %h expected 00000100", pc_q); end
        tests++;
        if (pc_next_q !== 32'h104) begin fails++; $display("FAIL load_next: got %h expected 00000104", pc_next_q); end
        load = 1'b0;
        tick();
        tests++;
        if (pc_q !== 32'h104) begin fails++; $display("FAIL load_then_en: got %h expected 00000104", pc_q); end
        load = 1'b1; en = 1'b0; load_addr = 32'h103;
        tick();
        tests++;
        if (pc_q !== 32'h103) begin fails++; $display("FAIL load_unaligned: got %h expected 00000103", pc_q); end
        load = 1'b0;
    endtask

    task automatic test_midreset();
        en = 1'b1;
        @(negedge clk);
        rst = 1'b1;
        #1;
        tests++;
        if (pc_q !== 32'h0) begin fails++; $display("FAIL midreset_async: got %h expected 00000000", pc_q); end
        tick();
        tests++;
        if (pc_q !== 32'h0) begin fails++; $display("FAIL midreset_hold: got %h expected 00000000", pc_q); end
        @(negedge clk);
        rst = 1'b0;
        tick();
        tests++;
        if (pc_q !== 32'h4) begin fails++; $display("FAIL midreset_release: got %h expected 00000004", pc_q); end
        en = 1'b0;
    endtask

    initial begin
        test_comb();
        test_wrap();
        test_reset();
        test_count();
        test_load();
        test_midreset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
